// File: rtl/saturn_vdp1_erase_pkg.sv
// -----------------------------------------------------------------------------
// saturn_vdp1_pkg
// Shared VDP1 definitions: the EWLR/EWRR corner layout, the erase engine
// state encoding and the framebuffer geometry constants. Imported by the
// erase engine and by the register file that owns EWLR/EWRR.
// -----------------------------------------------------------------------------
package saturn_vdp1_pkg;

    // EWLR / EWRR layout: [15:9] X in 8-word units, [8:0] Y line
    typedef struct packed {
        logic [6:0] x;
        logic [8:0] y;
    } ew_coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } erase_state_t;

    // Words per EWLR/EWRR X unit
    localparam int unsigned EW_X_UNIT      = 8;
    // log2 of words per framebuffer line
    localparam int unsigned FB_STRIDE_LOG2 = 9;

endpackage

// File: rtl/saturn_vdp1_erase_if.sv
// -----------------------------------------------------------------------------
// saturn_vdp1_erase_if
// Framebuffer write request channel (valid/ready) between the VDP1 erase
// engine and the framebuffer SDRAM arbiter.
//   fb_valid : write request valid          (master -> slave)
//   fb_ready : request accepted this cycle  (slave  -> master)
//   fb_addr  : framebuffer word address     (master -> slave)
//   fb_data  : 16-bit write data            (master -> slave)
// -----------------------------------------------------------------------------
interface saturn_vdp1_erase_if #(
    parameter int ADDR_W = 17
) ();
    logic              fb_valid;
    logic              fb_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;

    modport master (output fb_valid, output fb_addr, output fb_data, input fb_ready);
    modport slave  (input fb_valid, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/saturn_vdp1_erase.sv
// -----------------------------------------------------------------------------
// saturn_vdp1_erase
// VDP1 framebuffer erase/write engine. On a start pulse it latches EWDR, EWLR
// and EWRR and fills the selected rectangle of the back framebuffer with the
// EWDR colour, one word per accepted request.
// Ports:
//   MCLK, RESET_N       : clock (rising edge) and async active-low reset
//   start / abort       : one-cycle pulses to begin / stop an erase
//   ewdr, ewlr, ewrr    : fill word, upper-left and lower-right corners
//   fb (master)         : valid/ready write request channel to the arbiter
//   busy                : engine active (WRITE or FINISH)
//   done / aborted      : one-cycle completion / abort pulses
// -----------------------------------------------------------------------------
module saturn_vdp1_erase
    import saturn_vdp1_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int STRIDE_LOG2 = FB_STRIDE_LOG2
) (
    input  logic                 MCLK,
    input  logic                 RESET_N,
    input  logic                 start,
    input  logic                 abort,
    input  logic [15:0]          ewdr,
    input  logic [15:0]          ewlr,
    input  logic [15:0]          ewrr,
    saturn_vdp1_erase_if.master  fb,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    // Last word of a line that physically exists (stride - 1)
    localparam logic [9:0] X_LIMIT = 10'((1 << STRIDE_LOG2) - 1);

    erase_state_t      state_q, state_d;
    logic [9:0]        xs_q, xs_d;
    logic [9:0]        xe_q, xe_d;
    logic [8:0]        ye_q, ye_d;
    logic [9:0]        cx_q, cx_d;
    logic [8:0]        cy_q, cy_d;
    logic              fb_valid_q, fb_valid_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]       fb_data_q, fb_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    ew_coord_t         lr_s;
    ew_coord_t         rr_s;
    logic [9:0]        xs_s;
    logic [9:0]        xe_raw_s;
    logic [9:0]        xe_eff_s;
    logic              empty_s;

    // Line address: Y above the stride bits, truncated so Y wraps.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [8:0] y, input logic [9:0] x);
        return ADDR_W'((32'(y) << STRIDE_LOG2) | 32'(x & X_LIMIT));
    endfunction

    // Decode the corner registers into word ranges for the start decision
    always_comb begin
        lr_s     = ew_coord_t'(ewlr);
        rr_s     = ew_coord_t'(ewrr);
        xs_s     = 10'(lr_s.x) * 10'(EW_X_UNIT);
        xe_raw_s = 10'(rr_s.x) * 10'(EW_X_UNIT) - 10'd1;
        // Words past the stride are never written, so clip the X end there;
        // a rectangle starting past the stride has nothing to write at all.
        xe_eff_s = (xe_raw_s > X_LIMIT) ? X_LIMIT : xe_raw_s;
        empty_s  = (rr_s.x <= lr_s.x) || (rr_s.y < lr_s.y) || (xs_s > X_LIMIT);
    end

    // Next-state and next-output logic for the erase FSM and address counters
    always_comb begin
        state_d    = state_q;
        xs_d       = xs_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        fb_valid_d = fb_valid_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;

        case (state_q)
            IDLE: begin
                fb_valid_d = 1'b0;
                busy_d     = 1'b0;
                if (start && !abort) begin
                    xs_d      = xs_s;
                    xe_d      = xe_eff_s;
                    ye_d      = rr_s.y;
                    fb_data_d = ewdr;
                    busy_d    = 1'b1;
                    if (empty_s) begin
                        state_d = FINISH;
                    end else begin
                        cx_d       = xs_s;
                        cy_d       = lr_s.y;
                        fb_addr_d  = word_addr(lr_s.y, xs_s);
                        fb_valid_d = 1'b1;
                        state_d    = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            WRITE: begin
                if (abort) begin
                    // A word accepted in the abort cycle still counts as written
                    fb_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    aborted_d  = 1'b1;
                    state_d    = IDLE;
                end else if (fb.fb_ready) begin
                    if (cx_q != xe_q) begin
                        cx_d      = cx_q + 10'd1;
                        fb_addr_d = word_addr(cy_q, cx_q + 10'd1);
                    end else if (cy_q != ye_q) begin
                        cx_d      = xs_q;
                        cy_d      = cy_q + 9'd1;
                        fb_addr_d = word_addr(cy_q + 9'd1, xs_q);
                    end else begin
                        fb_valid_d = 1'b0;
                        state_d    = FINISH;
                    end
                end else begin
                    // Hold the request until the arbiter takes it
                    state_d = WRITE;
                end
            end

            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (abort) begin
                    aborted_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                fb_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            xs_q       <= 10'd0;
            xe_q       <= 10'd0;
            ye_q       <= 9'd0;
            cx_q       <= 10'd0;
            cy_q       <= 9'd0;
            fb_valid_q <= 1'b0;
            fb_addr_q  <= {ADDR_W{1'b0}};
            fb_data_q  <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            xs_q       <= xs_d;
            xe_q       <= xe_d;
            ye_q       <= ye_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            fb_valid_q <= fb_valid_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign fb.fb_valid = fb_valid_q;
    assign fb.fb_addr  = fb_addr_q;
    assign fb.fb_data  = fb_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_saturn_vdp1_erase.sv
// -----------------------------------------------------------------------------
// tb_saturn_vdp1_erase
// Self-checking bench for the VDP1 erase engine. Expected write sequences come
// from a rectangle model (nested loops over Y and X with the stride clip and
// the Y wrap); observed accepted writes are collected per run and compared.
// -----------------------------------------------------------------------------
module tb_saturn_vdp1_erase;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic        start;
    logic        abort;
    logic [15:0] ewdr;
    logic [15:0] ewlr;
    logic [15:0] ewrr;
    logic        busy;
    logic        done;
    logic        aborted;

    saturn_vdp1_erase_if #(.ADDR_W(17)) fb_if ();

    saturn_vdp1_erase #(.ADDR_W(17), .STRIDE_LOG2(9)) dut (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .start   (start),
        .abort   (abort),
        .ewdr    (ewdr),
        .ewlr    (ewlr),
        .ewrr    (ewrr),
        .fb      (fb_if),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    always #5 MCLK = ~MCLK;

    int checks   = 0;
    int failures = 0;

    int exp_addr[$];
    int obs_addr[$];
    int obs_data[$];

    int first_valid, done_cyc, done_count, aborted_cyc, aborted_count;
    int abort_cyc, busy_cycles, valid_cycles, hold_viol, ready_at_abort;
    logic valid_at_end;
    logic timed_out;

    // Reference model: words of the rectangle in raster order
    function automatic void build_exp(input logic [15:0] lr, input logic [15:0] rr);
        int xs, xe, ys, ye;
        exp_addr.delete();
        xs = int'(lr[15:9]) * 8;
        xe = int'(rr[15:9]) * 8 - 1;
        ys = int'(lr[8:0]);
        ye = int'(rr[8:0]);
        for (int y = ys; y <= ye; y++)
            for (int x = xs; x <= xe; x++)
                if (x < 512) exp_addr.push_back((y % 256) * 512 + x);
    endfunction

    // Counts differences between the observed and modelled write streams
    function automatic int seq_mismatches(input int d);
        int m;
        m = (obs_addr.size() == exp_addr.size()) ? 0 : 1;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] != exp_addr[i] || obs_data[i] != d) m++;
        return m;
    endfunction

    // Starts an erase, plays the arbiter, and records what the DUT does
    task automatic run_erase(input logic [15:0] d, input logic [15:0] lr, input logic [15:0] rr,
                             input int mode, input int abort_after, input int restart_at);
        int c, budget, accepts;
        logic v, pend, rdy, fin;
        logic [16:0] a, pa;
        logic [15:0] dv, pd;
        obs_addr.delete();
        obs_data.delete();
        first_valid = -1; done_cyc = -1; done_count = 0; aborted_cyc = -1; aborted_count = 0;
        abort_cyc = -1; busy_cycles = 0; valid_cycles = 0; hold_viol = 0; ready_at_abort = 0;
        valid_at_end = 1'b1;
        budget = 4 * exp_addr.size() + 20;
        ewdr = d; ewlr = lr; ewrr = rr; abort = 1'b0; fb_if.fb_ready = 1'b0; start = 1'b1;
        @(posedge MCLK); #1;
        c = 1; accepts = 0; pend = 1'b0; fin = 1'b0; pa = 17'd0; pd = 16'd0;
        while (!fin && c <= budget) begin
            v  = fb_if.fb_valid;
            a  = fb_if.fb_addr;
            dv = fb_if.fb_data;
            if (v && first_valid < 0) first_valid = c;
            if (v) valid_cycles++;
            if (busy) busy_cycles++;
            if (done) begin done_count++; done_cyc = c; end
            if (aborted) begin aborted_count++; aborted_cyc = c; valid_at_end = v; end
            if (pend && (!v || a !== pa || dv !== pd)) hold_viol++;
            if (done || aborted) begin
                fin = 1'b1;
            end else begin
                start = (c == restart_at);
                ewdr  = 16'($urandom);
                ewlr  = 16'($urandom);
                ewrr  = 16'($urandom);
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = c[0];
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                abort = 1'b0;
                if (abort_after >= 0 && v && accepts == abort_after && abort_cyc < 0) begin
                    abort = 1'b1;
                    abort_cyc = c;
                    ready_at_abort = int'(rdy);
                end
                fb_if.fb_ready = rdy;
                if (v && rdy) begin
                    obs_addr.push_back(int'(a));
                    obs_data.push_back(int'(dv));
                    accepts++;
                end
                pend = v && !rdy && !abort;
                pa = a; pd = dv;
                @(posedge MCLK); #1;
                c++;
            end
        end
        timed_out = !fin;
        start = 1'b0; abort = 1'b0; fb_if.fb_ready = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; start = 1'b0; abort = 1'b0; ewdr = 16'd0; ewlr = 16'd0; ewrr = 16'd0;
        fb_if.fb_ready = 1'b0;
        #12;
        checks++;
        if ({fb_if.fb_valid, busy, done, aborted} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 0000", {fb_if.fb_valid, busy, done, aborted});
        end
        checks++;
        if (fb_if.fb_addr !== 17'd0 || fb_if.fb_data !== 16'd0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%h data=%h required 0/0", fb_if.fb_addr, fb_if.fb_data);
        end
        @(negedge MCLK); RESET_N = 1'b1;
        @(posedge MCLK); #1;
        checks++;
        if (fb_if.fb_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got valid=%b busy=%b required 0/0", fb_if.fb_valid, busy);
        end
    endtask

    task automatic test_basic();
        build_exp(16'h0000, 16'h0401);
        run_erase(16'h8000, 16'h0000, 16'h0401, 0, -1, -1);
        checks++;
        if (timed_out || exp_addr.size() != 32) begin
            failures++;
            $display("FAIL basic_timeout: timed_out=%0d model_words=%0d required 0/32", timed_out, exp_addr.size());
        end
        checks++;
        if (seq_mismatches(16'h8000) != 0 || obs_addr[31] != 32'h0020F) begin
            failures++;
            $display("FAIL basic_seq: mismatches=%0d words=%0d required 0/32", seq_mismatches(16'h8000), obs_addr.size());
        end
        checks++;
        if (first_valid != 1) begin
            failures++;
            $display("FAIL basic_first_valid: got cycle %0d required 1", first_valid);
        end
        checks++;
        if (done_cyc - first_valid != 33 || done_count != 1) begin
            failures++;
            $display("FAIL basic_done_latency: got %0d (count %0d) required 33 (1)", done_cyc - first_valid, done_count);
        end
        @(posedge MCLK); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        build_exp(16'h0000, 16'h0401);
        run_erase(16'h8000, 16'h0000, 16'h0401, 1, -1, -1);
        checks++;
        if (hold_viol != 0) begin
            failures++;
            $display("FAIL bp_hold: violations=%0d required 0", hold_viol);
        end
        checks++;
        if (timed_out || seq_mismatches(16'h8000) != 0 || done_count != 1) begin
            failures++;
            $display("FAIL bp_seq: mismatches=%0d done_count=%0d required 0/1", seq_mismatches(16'h8000), done_count);
        end
    endtask

    task automatic test_empty();
        build_exp(16'h0405, 16'h0405);
        run_erase(16'h5555, 16'h0405, 16'h0405, 0, -1, -1);
        checks++;
        if (valid_cycles != 0 || obs_addr.size() != 0) begin
            failures++;
            $display("FAIL empty_writes: valid_cycles=%0d required 0", valid_cycles);
        end
        checks++;
        if (done_cyc != 2 || busy_cycles != 1) begin
            failures++;
            $display("FAIL empty_timing: done_cyc=%0d busy_cycles=%0d required 2/1", done_cyc, busy_cycles);
        end
        // X starting past the stride writes nothing
        build_exp({7'd64, 9'd3}, {7'd70, 9'd4});
        run_erase(16'h1111, {7'd64, 9'd3}, {7'd70, 9'd4}, 0, -1, -1);
        checks++;
        if (valid_cycles != 0 || done_cyc != 2 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL offstride_empty: valid_cycles=%0d done_cyc=%0d required 0/2", valid_cycles, done_cyc);
        end
    endtask

    task automatic test_stride_wrap();
        build_exp({7'd62, 9'd255}, {7'd66, 9'd256});
        run_erase(16'hA5A5, {7'd62, 9'd255}, {7'd66, 9'd256}, 2, -1, -1);
        checks++;
        if (timed_out || seq_mismatches(16'hA5A5) != 0 || obs_addr.size() != 32) begin
            failures++;
            $display("FAIL stride_wrap_seq: mismatches=%0d words=%0d required 0/32", seq_mismatches(16'hA5A5), obs_addr.size());
        end
        checks++;
        if (obs_addr.size() == 32 && (obs_addr[15] != 32'h1FFFF || obs_addr[16] != 32'h001F0)) begin
            failures++;
            $display("FAIL stride_wrap_edges: got %h/%h required 1ffff/001f0", obs_addr[15], obs_addr[16]);
        end
    endtask

    task automatic test_abort();
        int m;
        build_exp(16'h0000, 16'h0402);
        run_erase(16'h7777, 16'h0000, 16'h0402, 2, 10, -1);
        m = (obs_addr.size() == 10 + ready_at_abort) ? 0 : 1;
        for (int i = 0; i < obs_addr.size(); i++)
            if (obs_addr[i] != exp_addr[i]) m++;
        checks++;
        if (timed_out || m != 0) begin
            failures++;
            $display("FAIL abort_words: words=%0d required %0d (mismatches=%0d)", obs_addr.size(), 10 + ready_at_abort, m);
        end
        checks++;
        if (aborted_count != 1 || aborted_cyc != abort_cyc + 1 || valid_at_end !== 1'b0 || done_count != 0) begin
            failures++;
            $display("FAIL abort_pulse: aborted=%0d@%0d valid=%b done=%0d required 1@%0d 0 0",
                     aborted_count, aborted_cyc, valid_at_end, done_count, abort_cyc + 1);
        end
        m = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge MCLK); #1;
            if (done !== 1'b0 || busy !== 1'b0 || aborted !== 1'b0 || fb_if.fb_valid !== 1'b0) m++;
        end
        checks++;
        if (m != 0) begin
            failures++;
            $display("FAIL abort_quiet: active cycles=%0d required 0", m);
        end
        run_erase(16'h1234, 16'h0000, 16'h0402, 0, -1, -1);
        checks++;
        if (timed_out || seq_mismatches(16'h1234) != 0 || done_count != 1) begin
            failures++;
            $display("FAIL abort_restart: mismatches=%0d done_count=%0d required 0/1", seq_mismatches(16'h1234), done_count);
        end
    endtask

    task automatic test_start_ignored();
        build_exp(16'h0000, 16'h0401);
        run_erase(16'h0F0F, 16'h0000, 16'h0401, 0, -1, 5);
        checks++;
        if (timed_out || seq_mismatches(16'h0F0F) != 0 || done_count != 1 || done_cyc != 34) begin
            failures++;
            $display("FAIL start_ignored: mismatches=%0d done_cyc=%0d required 0/34", seq_mismatches(16'h0F0F), done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int lx, ly, rx, ry;
        logic [15:0] lr, rr, d;
        for (int k = 0; k < 6; k++) begin
            lx = $urandom_range(0, 6);
            ly = $urandom_range(0, 510);
            rx = lx + $urandom_range(0, 3);
            ry = ly + $urandom_range(0, 3) - 1;
            if (ry > 511) ry = 511;
            lr = {7'(lx), 9'(ly)};
            rr = {7'(rx), 9'(ry)};
            d  = 16'($urandom);
            build_exp(lr, rr);
            run_erase(d, lr, rr, 2, -1, -1);
            checks++;
            if (timed_out || seq_mismatches(d) != 0 || done_count != 1 || hold_viol != 0) begin
                failures++;
                $display("FAIL b2b_%0d: lr=%h rr=%h mismatches=%0d done=%0d hold=%0d required 0/1/0",
                         k, lr, rr, seq_mismatches(d), done_count, hold_viol);
            end
        end
    endtask

    task automatic test_reset_mid();
        int m;
        ewdr = 16'h4444; ewlr = 16'h0000; ewrr = 16'h0401; fb_if.fb_ready = 1'b1; start = 1'b1;
        @(posedge MCLK); #1;
        start = 1'b0;
        repeat (6) @(posedge MCLK);
        #3;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({fb_if.fb_valid, busy, done, aborted} !== 4'b0000 || fb_if.fb_addr !== 17'd0 || fb_if.fb_data !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_async: ctrl=%b addr=%h data=%h required 0",
                     {fb_if.fb_valid, busy, done, aborted}, fb_if.fb_addr, fb_if.fb_data);
        end
        repeat (2) @(posedge MCLK);
        @(negedge MCLK); RESET_N = 1'b1;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge MCLK); #1;
            if (fb_if.fb_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) m++;
        end
        checks++;
        if (m != 0) begin
            failures++;
            $display("FAIL reset_mid_after: active cycles=%0d required 0", m);
        end
        fb_if.fb_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_stride_wrap();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/saturn_vdp1_erase.md
Name: saturn_vdp1_erase

Overview:
Framebuffer erase/write engine for VDP1. It sits directly downstream of the VDP1 register file and consumes EWDR, EWLR and EWRR. On a start pulse it fills the selected rectangle of the back framebuffer with the EWDR colour, one 16-bit word at a time. Writes go over a valid/ready request port to the framebuffer SDRAM arbiter.

Parameters:
ADDR_W, 17, framebuffer word-address width (128K words = 256 KB)
STRIDE_LOG2, 9, log2 of words per framebuffer line (512)

Ports:
MCLK  input  1  system clock (MCLK1); all logic is on its rising edge
RESET_N  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins an erase (frame change)
abort  input  1  one-cycle pulse that stops an erase in progress (erase window closed)
ewdr  input  16  fill word
ewlr  input  16  upper-left corner: [15:9] X in 8-word units, [8:0] Y line
ewrr  input  16  lower-right corner: [15:9] X (exclusive), [8:0] Y (inclusive)
fb_valid  output  1  write request valid
fb_ready  input  1  arbiter accepts the request this cycle
fb_addr  output  ADDR_W  framebuffer word address
fb_data  output  16  write data
busy  output  1  engine is active
done  output  1  one-cycle pulse when the rectangle has been completed
aborted  output  1  one-cycle pulse when an erase ends because of abort

Behaviour:
- Reset values: fb_valid=0, fb_addr=0, fb_data=0, busy=0, done=0, aborted=0. The FSM goes to IDLE. Reset is honoured mid-erase with no further writes.
- FSM states: IDLE, WRITE, FINISH.
- IDLE, when start=1 and abort=0:
  - Latch ewdr, ewlr and ewrr into internal copies. Later register changes have no effect on the running erase.
  - Word X range is xs = ewlr[15:9]*8 to xe = ewrr[15:9]*8 - 1, inclusive. Y range is ys = ewlr[8:0] to ye = ewrr[8:0].
  - Empty rectangle (ewrr X <= ewlr X, or ewrr Y < ewlr Y): go to FINISH, with no writes.
  - Otherwise: cx=xs, cy=ys, go to WRITE.
- start with abort in the same cycle: start is ignored.
- start while busy: ignored.
- WRITE:
  - fb_valid=1, fb_data = latched ewdr, fb_addr = {cy, cx[STRIDE_LOG2-1:0]} truncated to ADDR_W. Only the low ADDR_W-STRIDE_LOG2 bits of cy are kept, so Y wraps.
  - Outputs hold stable until fb_ready=1 (AXI-style: valid never drops without ready).
  - On accept, the next address is presented the following cycle (one word per cycle at full rate):
    - If cx != xe: cx++.
    - Else if cy != ye: cx=xs, cy++.
    - Else: go to FINISH, and fb_valid=0 from the next cycle.
- X word counter is 10 bits (max xe = 127*8-1 = 1015). Words with cx >= 2^STRIDE_LOG2 are skipped and not written: that line's X loop ends early at the stride limit.
- FINISH: one cycle with done=1, then IDLE.
- busy=1 in WRITE and FINISH, 0 in IDLE. busy rises the cycle after start.
- abort in WRITE or FINISH:
  - Go to IDLE next cycle, fb_valid=0, aborted=1 for one cycle, done not pulsed.
  - If fb_ready=1 in the abort cycle, that word counts as written.
- abort in IDLE: no effect.
- Latency: first fb_valid appears 1 cycle after start. A rectangle of N words with fb_ready held high asserts done N+1 cycles after the first fb_valid.

Decomposition:
- Shared package saturn_vdp1_pkg:
  - ew_coord_t struct (x[6:0], y[8:0]) used to unpack EWLR/EWRR.
  - erase_state_t enum (IDLE, WRITE, FINISH).
  - Constants EW_X_UNIT=8, FB_STRIDE_LOG2=9.
- The register file also imports the package for the EWLR/EWRR layout.
- No sub-module is needed: the address generator is two counters inside the FSM.

Test Plan:
- ewlr=0x0000, ewrr=0x0401 (X=2, Y=1), ewdr=0x8000, fb_ready=1, start: 32 writes; addresses 0x00000–0x0000F then 0x00200–0x0020F; data 0x8000; done 33 cycles after the first valid.
- Same rectangle with fb_ready toggling 1/0 each cycle: addr/data hold stable while ready=0; 32 writes in order; done once.
- ewlr=0x0405, ewrr=0x0405 (empty X range): zero fb_valid cycles; done 2 cycles after start; busy high for exactly 1 cycle.
- Full screen ewlr=0x0000, ewrr=0x80FF (X=64, Y=255): 512*256 = 131072 writes; last address 0x1FFFF.
- abort after the 10th accepted write: fb_valid drops next cycle; aborted pulses; done stays 0. A following start with new ewdr=0x1234 restarts at xs,ys.
- start during WRITE with different ewlr: ignored; address sequence unchanged. Reset mid-erase: all outputs 0 asynchronously.
